// File: rtl/br_checkpoint_stack_pkg.sv
// Shared types for the branch checkpoint stack.
//   TAG_W       physical tag width, derived from the ROB size macro N_ENTRY_ROB
//   N_REG       architectural registers covered by one map-table snapshot
//   N_CKPT_DEF  default checkpoint count; ckpt_id_t is the matching id type
//   map_snap_t  one map-table snapshot: tag table plus ready bits
//   cdb_match   per-register hit vector of a tag table against the two CDB tags
`ifndef N_ENTRY_ROB
`define N_ENTRY_ROB 32
`endif

package br_checkpoint_stack_pkg;

   localparam int TAG_W      = $clog2(`N_ENTRY_ROB + 33);
   localparam int N_REG      = 32;
   localparam int N_CKPT_DEF = 4;
   localparam int ID_W_DEF   = $clog2(N_CKPT_DEF);

   typedef logic [ID_W_DEF-1:0] ckpt_id_t;
   typedef logic [TAG_W-1:0]    tag_t;

   typedef struct packed {
      tag_t [N_REG-1:0]   tag;
      logic [N_REG-1:0]   ready;
   } map_snap_t;

   function automatic logic [N_REG-1:0] cdb_match(input tag_t [N_REG-1:0] tags,
                                                  input tag_t c0,
                                                  input tag_t c1);
      logic [N_REG-1:0] m;
      m = '0;
      for (int i = 0; i < N_REG; i++) begin
         m[i] = (tags[i] == c0) || (tags[i] == c1);
      end
      return m;
   endfunction

endpackage

// File: rtl/br_checkpoint_stack_ckpt_entry.sv
// One checkpoint slot: holds a map-table snapshot and keeps its ready bits
// current by snooping the CDB while the slot is live.
// Ports:
//   clock          posedge clock
//   wr_en          capture wr_snap this cycle
//   wr_snap        snapshot to capture (ready bits merged with same-cycle CDB hits)
//   live           slot holds a live checkpoint; enables CDB snooping
//   cdb_0, cdb_1   completing tags
//   tag            stored tag table
//   ready_merged   stored ready bits OR'ed with same-cycle CDB hits
module ckpt_entry
   import br_checkpoint_stack_pkg::*;
(
   input  logic               clock,
   input  logic               wr_en,
   input  map_snap_t          wr_snap,
   input  logic               live,
   input  tag_t               cdb_0,
   input  tag_t               cdb_1,
   output tag_t [N_REG-1:0]   tag,
   output logic [N_REG-1:0]   ready_merged
);

   // Contents are don't-care until written, so the slot carries no reset.
   map_snap_t snap_q;

   always_ff @(posedge clock) begin
      if (wr_en) begin
         snap_q.tag   <= wr_snap.tag;
         snap_q.ready <= wr_snap.ready | cdb_match(wr_snap.tag, cdb_0, cdb_1);
      end else if (live) begin
         snap_q.ready <= snap_q.ready | cdb_match(snap_q.tag, cdb_0, cdb_1);
      end
   end

   assign tag          = snap_q.tag;
   assign ready_merged = snap_q.ready | cdb_match(snap_q.tag, cdb_0, cdb_1);

endmodule

// File: rtl/br_checkpoint_stack.sv
// Branch checkpoint stack: circular buffer of map-table snapshots, one per
// in-flight branch. A save captures the rename map snapshot at dispatch; a
// mispredicted resolve returns that snapshot (CDB-merged) to the map table in
// the same cycle and rolls the buffer back to just after the branch.
// Optional feature macro: CKPT_SQUASH_MASK_EN adds br_squash_mask.
// Ports:
//   clock, reset                    posedge clock, synchronous active-high reset
//   ckpt_save                       capture snap_tag_table/snap_ready_table
//   ckpt_id                         id given to a save this cycle (tail)
//   ckpt_full                       all checkpoints in use; stall branch dispatch
//   CDB_in_0, CDB_in_1              completing tags, snooped into stored ready bits
//   resolve_valid/_id/_mispredict   branch resolution
//   recovery_br                     map table must recover this cycle
//   recovery_Tag_table/_ready_table snapshot for recovery
//   br_squash_mask                  resolve_id plus younger live ids (macro only)
// Handshake: recovery_br is a valid-only strobe with no back-pressure; the map
// table must consume recovery_* in the cycle recovery_br is high. ckpt_full is
// the ready for ckpt_save; a save while full is dropped.
module br_checkpoint_stack
   import br_checkpoint_stack_pkg::*;
#(
   parameter  int N_CKPT = N_CKPT_DEF,
   localparam int ID_W   = $clog2(N_CKPT)
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    ckpt_save,
   input  logic [32*TAG_W-1:0]     snap_tag_table,
   input  logic [31:0]             snap_ready_table,
   output logic [ID_W-1:0]         ckpt_id,
   output logic                    ckpt_full,
   input  logic [TAG_W-1:0]        CDB_in_0,
   input  logic [TAG_W-1:0]        CDB_in_1,
   input  logic                    resolve_valid,
   input  logic [ID_W-1:0]         resolve_id,
   input  logic                    resolve_mispredict,
   output logic                    recovery_br,
   output logic [32*TAG_W-1:0]     recovery_Tag_table,
   output logic [31:0]             recovery_ready_table
`ifdef CKPT_SQUASH_MASK_EN
   ,
   output logic [N_CKPT-1:0]       br_squash_mask
`endif
);

   localparam int CNT_W = ID_W + 1;

   logic [ID_W-1:0]   head_q, tail_q, head_nx, tail_nx, age_r, sel_id;
   logic [CNT_W-1:0]  count_q, count_nx, count_pre, skip;
   logic [N_CKPT-1:0] valid_q, valid_nx, ent_wr;
   logic              save_ok, mp, cr, stop;
   map_snap_t         snap_in;

   tag_t [N_REG-1:0]  ent_tag   [N_CKPT];
   logic [N_REG-1:0]  ent_ready [N_CKPT];

   assign snap_in   = {snap_tag_table, snap_ready_table};
   assign ckpt_full = (count_q == CNT_W'(N_CKPT));
   assign ckpt_id   = tail_q;
   assign age_r     = resolve_id - head_q;

   // Resolves naming a dead slot are ignored entirely.
   assign mp = !reset && resolve_valid && resolve_mispredict && valid_q[resolve_id];
   assign cr = !reset && resolve_valid && !resolve_mispredict && valid_q[resolve_id];
   // Any mispredict in flight makes a same-cycle save wrong-path.
   assign save_ok = !reset && ckpt_save && !ckpt_full && !(resolve_valid && resolve_mispredict);

   always_comb begin
      ent_wr = '0;
      for (int i = 0; i < N_CKPT; i++) begin
         ent_wr[i] = save_ok && (tail_q == ID_W'(i));
      end
   end

   for (genvar g = 0; g < N_CKPT; g++) begin : g_ent
      ckpt_entry u_ent (
         .clock        (clock),
         .wr_en        (ent_wr[g]),
         .wr_snap      (snap_in),
         .live         (valid_q[g]),
         .cdb_0        (CDB_in_0),
         .cdb_1        (CDB_in_1),
         .tag          (ent_tag[g]),
         .ready_merged (ent_ready[g])
      );
   end

   // Next-state: first apply the event to valid/tail/count, then let head
   // sweep over any run of dead slots at the old end of the buffer.
   always_comb begin
      valid_nx  = valid_q;
      tail_nx   = tail_q;
      count_pre = count_q;
      if (mp) begin
         for (int i = 0; i < N_CKPT; i++) begin
            if ((ID_W'(i) - head_q) > age_r) valid_nx[i] = 1'b0;
         end
         valid_nx[resolve_id] = 1'b0;
         tail_nx   = resolve_id + 1'b1;
         count_pre = {1'b0, age_r} + CNT_W'(1);
      end else begin
         if (cr) valid_nx[resolve_id] = 1'b0;
         if (save_ok) begin
            valid_nx[tail_q] = 1'b1;
            tail_nx   = tail_q + 1'b1;
            count_pre = count_q + CNT_W'(1);
         end
      end

      skip = '0;
      stop = 1'b0;
      for (int k = 0; k < N_CKPT; k++) begin
         if (!stop && (CNT_W'(k) < count_pre) && !valid_nx[head_q + ID_W'(k)]) begin
            skip = skip + CNT_W'(1);
         end else begin
            stop = 1'b1;
         end
      end
      head_nx  = head_q + skip[ID_W-1:0];
      count_nx = count_pre - skip;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         valid_q <= '0;
      end else begin
         head_q  <= head_nx;
         tail_q  <= tail_nx;
         count_q <= count_nx;
         valid_q <= valid_nx;
      end
   end

   // Outside a recovery the tables just show the oldest slot.
   assign sel_id               = mp ? resolve_id : head_q;
   assign recovery_br          = mp;
   assign recovery_Tag_table   = ent_tag[sel_id];
   assign recovery_ready_table = ent_ready[sel_id];

`ifdef CKPT_SQUASH_MASK_EN
   always_comb begin
      br_squash_mask = '0;
      if (mp) begin
         for (int i = 0; i < N_CKPT; i++) begin
            if ((ID_W'(i) == resolve_id) ||
                (valid_q[i] && ((ID_W'(i) - head_q) > age_r))) begin
               br_squash_mask[i] = 1'b1;
            end
         end
      end
   end
`endif

endmodule
